memory_access_initiator: RTL and testbench
==========================================

MEMORY_ACCESS_INITIATOR -- requirements
Module: memory_access_initiator

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: port clk (rising edge) and port Reset.
REQ-002 Parameter ADDR_WIDTH, default 9: memory address width.
REQ-003 Parameter DATA_WIDTH, default 8: memory data width.
REQ-004 Parameter RSP_DEPTH, default 4: response FIFO entries; power of 2, minimum 4.
REQ-005 Port clk, input, 1: sole clock for the block and for the memory tile.
REQ-006 Port Reset, input, 1: asynchronous active-high reset.
REQ-007 Port cmd_valid, input, 1: command offered.
REQ-008 Port cmd_ready, output, 1: command accepted when cmd_valid and cmd_ready are both high.
REQ-009 Port cmd_we, input, 1: 1 = write, 0 = read.
REQ-010 Port cmd_addr, input, ADDR_WIDTH: target address.
REQ-011 Port cmd_wdata, input, DATA_WIDTH: write data, ignored for reads.
REQ-012 Port rsp_valid, output, 1: read data available.
REQ-013 Port rsp_ready, input, 1: consumer takes the response.
REQ-014 Port rsp_rdata, output, DATA_WIDTH: read data.
REQ-015 Ports mem_waddr (ADDR_WIDTH), mem_raddr (ADDR_WIDTH), mem_data_in (DATA_WIDTH), mem_wen (1) and mem_ren (1) SHALL be outputs that drive the memory tile's waddr, raddr, data_in, wen and ren pins.
REQ-016 Port mem_data_out, input, DATA_WIDTH: driven by the memory tile's data_out.

Function
REQ-017 An accepted write (cmd_we=1) in cycle T SHALL drive mem_wen=1, mem_waddr=cmd_addr and mem_data_in=cmd_wdata in cycle T+1, from registers.
REQ-018 An accepted read in cycle T SHALL drive mem_ren=1 and mem_raddr=cmd_addr in cycle T+1, from registers.
REQ-019 The memory has a synchronous read of latency 1, so data for a read issued in T+1 SHALL be sampled from mem_data_out at the end of cycle T+2.
REQ-020 The sampled data SHALL be pushed into the response FIFO, giving rsp_valid=1 no earlier than T+3.
REQ-021 mem_wen and mem_ren SHALL each be a single-cycle pulse per command and SHALL never both be high in the same cycle.
REQ-022 When no command is issued, mem_waddr, mem_raddr and mem_data_in SHALL hold their last values.
REQ-023 The block SHALL keep a credit count: reads_in_flight (issue stage plus capture stage) + fifo_count.
REQ-024 cmd_ready SHALL be 1 exactly when credit count < RSP_DEPTH, for reads and writes alike, so a response is never dropped.
REQ-025 With RSP_DEPTH>=4 and rsp_ready held at 1, the block SHALL sustain one command per cycle, including back-to-back reads.
REQ-026 Responses SHALL be returned in issue order, rsp_rdata SHALL be stable while rsp_valid=1 and rsp_ready=0, and a pop SHALL occur on rsp_valid and rsp_ready.
REQ-027 A FIFO push and pop in the same cycle SHALL leave occupancy unchanged and SHALL be legal both when the FIFO is full and when it is empty; on an empty FIFO, the pushed entry becomes visible next cycle.
REQ-028 A read accepted in the cycle after a write to the same address SHALL return the new data.
REQ-029 FIFO pointers SHALL wrap modulo RSP_DEPTH, with one extra bit used to distinguish full from empty.
REQ-030 Port busy is not provided: idle is identified by credit count == 0 and cmd_valid == 0.

Reset
REQ-031 While Reset=1, outputs SHALL be: cmd_ready=0, rsp_valid=0, mem_wen=0, mem_ren=0, and all address/data outputs 0.
REQ-032 In the first cycle after Reset deasserts, cmd_ready SHALL be 1.
REQ-033 Reset mid-operation SHALL discard in-flight reads and FIFO contents; no stale response SHALL appear after release.

Structure
REQ-034 Default widths and depth constants SHALL live in the shared package memory_access_pkg.
REQ-035 The response buffer SHALL be the sub-module memory_rsp_fifo, parameterised by DATA_WIDTH and RSP_DEPTH.

Verification
REQ-036 Write then read: write 0x1A5 <- 0x3C, then read 0x1A5 -> mem_wen pulses in T+1, and rsp_rdata=0x3C arrives exactly 3 cycles after the read handshake.
REQ-037 Streaming reads: 8 back-to-back reads of addresses 0..7 preloaded with data = addr^0x55, rsp_ready=1 -> cmd_ready is never low, and 8 in-order responses 0x55..0x52 arrive on consecutive cycles.
REQ-038 Backpressure: rsp_ready=0 with 6 reads offered -> exactly 4 accepted and cmd_ready=0 thereafter; then rsp_ready=1 -> 4 responses in order, after which the remaining 2 reads are accepted.
REQ-039 Read-after-write: write 0x000 <- 0xFF in cycle T, read 0x000 in T+1 -> response 0xFF; mem_wen and mem_ren are never high together.
REQ-040 Reset mid-flight: assert Reset one cycle after 2 reads are accepted -> rsp_valid stays 0 after release, and cmd_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/memory_access_pkg.sv
// Shared defaults and small helpers for the memory access initiator and its response FIFO.
package memory_access_pkg;

  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_RSP_DEPTH  = 4;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_kind_e;

  // Credit counter must hold RSP_DEPTH plus the two read stages in flight.
  function automatic int credit_width(input int depth);
    return $clog2(depth) + 2;
  endfunction

endpackage

// File: rtl/memory_rsp_fifo.sv
// Response FIFO for read data; pointers carry one extra wrap bit to tell full from empty.
module memory_rsp_fifo
  import memory_access_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop_ready,
  output logic                          pop_valid,
  output logic [DATA_WIDTH-1:0]         pop_data,
  output logic [$clog2(RSP_DEPTH):0]    count
);

  localparam int PW    = $clog2(RSP_DEPTH);
  localparam int CNT_W = PW + 1;

  logic [DATA_WIDTH-1:0] store [RSP_DEPTH];
  logic [PW:0]           wptr;
  logic [PW:0]           rptr;
  logic                  empty;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (count == CNT_W'(RSP_DEPTH));
  assign do_pop  = pop_ready & ~empty;
  // A pop frees the head slot in the same cycle, so a push into a full FIFO is legal then.
  assign do_push = push & (~full | do_pop);

  assign pop_valid = ~empty;
  assign pop_data  = empty ? '0 : store[rptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/memory_access_initiator.sv
// Turns a valid/ready command stream into registered memory tile strobes and returns read data in order.
module memory_access_initiator
  import memory_access_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam int CW = credit_width(RSP_DEPTH);
  localparam int FW = $clog2(RSP_DEPTH) + 1;

  logic                  cmd_fire;
  logic                  wen_p0;
  logic                  ren_p0;
  logic [ADDR_WIDTH-1:0] waddr_p0;
  logic [ADDR_WIDTH-1:0] raddr_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;
  logic                  vld_p1;
  logic [FW-1:0]         fifo_count;
  logic [CW-1:0]         credit;

  // Every read in the issue or capture stage already owns a FIFO slot, so it can never be dropped.
  assign credit    = CW'(ren_p0) + CW'(vld_p1) + CW'(fifo_count);
  assign cmd_ready = ~Reset & (credit < CW'(RSP_DEPTH));
  assign cmd_fire  = cmd_valid & cmd_ready;

  // Stage p0: registered strobes to the memory tile
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wen_p0   <= 1'b0;
      ren_p0   <= 1'b0;
      waddr_p0 <= '0;
      raddr_p0 <= '0;
      wdata_p0 <= '0;
    end else begin
      wen_p0 <= 1'b0;
      ren_p0 <= 1'b0;
      if (cmd_fire) begin
        if (cmd_kind_e'(cmd_we) == CMD_WRITE) begin
          wen_p0   <= 1'b1;
          waddr_p0 <= cmd_addr;
          wdata_p0 <= cmd_wdata;
        end else begin
          ren_p0   <= 1'b1;
          raddr_p0 <= cmd_addr;
        end
      end
    end
  end

  assign mem_wen     = wen_p0;
  assign mem_ren     = ren_p0;
  assign mem_waddr   = waddr_p0;
  assign mem_raddr   = raddr_p0;
  assign mem_data_in = wdata_p0;

  // Stage p1: memory read latency; mem_data_out is captured into the FIFO at the end of this stage
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) vld_p1 <= 1'b0;
    else       vld_p1 <= ren_p0;
  end

  memory_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .RSP_DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (Reset),
    .push      (vld_p1),
    .push_data (mem_data_out),
    .pop_ready (rsp_ready),
    .pop_valid (rsp_valid),
    .pop_data  (rsp_rdata),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_memory_access_initiator.sv
// Directed bench for memory_access_initiator with a behavioural latency-1 memory tile.
module tb_memory_access_initiator;

  localparam int AW = 9;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          Reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mem_waddr;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_data_in;
  logic          mem_wen;
  logic          mem_ren;
  logic [DW-1:0] mem_data_out;

  logic [DW-1:0] mem_model [512];
  int n_cmp   = 0;
  int n_bad   = 0;
  int collide = 0;

  always #5 clk = ~clk;

  memory_access_initiator dut (
    .clk          (clk),
    .Reset        (Reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_we       (cmd_we),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .mem_waddr    (mem_waddr),
    .mem_raddr    (mem_raddr),
    .mem_data_in  (mem_data_in),
    .mem_wen      (mem_wen),
    .mem_ren      (mem_ren),
    .mem_data_out (mem_data_out)
  );

  // Memory tile: synchronous read with latency 1, read-before-write on the same edge
  always @(posedge clk) begin
    if (mem_ren) mem_data_out <= mem_model[mem_raddr];
    if (mem_wen) mem_model[mem_waddr] = mem_data_in;
    if (mem_wen && mem_ren) collide++;
  end

  task automatic test_reset();
    Reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (mem_wen !== 1'b0) begin n_bad++; $display("FAIL rst_mem_wen: got %b want 0", mem_wen); end
    n_cmp++; if (mem_ren !== 1'b0) begin n_bad++; $display("FAIL rst_mem_ren: got %b want 0", mem_ren); end
    n_cmp++; if (mem_waddr !== 9'h000) begin n_bad++; $display("FAIL rst_mem_waddr: got %h want 000", mem_waddr); end
    n_cmp++; if (mem_raddr !== 9'h000) begin n_bad++; $display("FAIL rst_mem_raddr: got %h want 000", mem_raddr); end
    n_cmp++; if (mem_data_in !== 8'h00) begin n_bad++; $display("FAIL rst_mem_data_in: got %h want 00", mem_data_in); end
    n_cmp++; if (rsp_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_rsp_rdata: got %h want 00", rsp_rdata); end
    Reset = 1'b0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 9'h1A5; cmd_wdata = 8'h3C; rsp_ready = 1'b0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL wr_ready: got %b want 1", cmd_ready); end
    @(negedge clk);
    n_cmp++; if (mem_wen !== 1'b1) begin n_bad++; $display("FAIL wr_wen: got %b want 1", mem_wen); end
    n_cmp++; if (mem_waddr !== 9'h1A5) begin n_bad++; $display("FAIL wr_waddr: got %h want 1a5", mem_waddr); end
    n_cmp++; if (mem_data_in !== 8'h3C) begin n_bad++; $display("FAIL wr_data_in: got %h want 3c", mem_data_in); end
    n_cmp++; if (mem_ren !== 1'b0) begin n_bad++; $display("FAIL wr_no_ren: got %b want 0", mem_ren); end
    cmd_we = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++; if (mem_ren !== 1'b1) begin n_bad++; $display("FAIL rd_ren: got %b want 1", mem_ren); end
    n_cmp++; if (mem_raddr !== 9'h1A5) begin n_bad++; $display("FAIL rd_raddr: got %h want 1a5", mem_raddr); end
    n_cmp++; if (mem_wen !== 1'b0) begin n_bad++; $display("FAIL wr_pulse: got %b want 0", mem_wen); end
    n_cmp++; if (mem_data_in !== 8'h3C) begin n_bad++; $display("FAIL wr_data_hold: got %h want 3c", mem_data_in); end
    @(negedge clk);
    n_cmp++; if (mem_ren !== 1'b0) begin n_bad++; $display("FAIL rd_pulse: got %b want 0", mem_ren); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_early: got %b want 0", rsp_valid); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rd_valid_t3: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 8'h3C) begin n_bad++; $display("FAIL rd_data: got %h want 3c", rsp_rdata); end
    @(negedge clk);
    n_cmp++; if (rsp_rdata !== 8'h3C) begin n_bad++; $display("FAIL rd_hold: got %h want 3c", rsp_rdata); end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_popped: got %b want 0", rsp_valid); end
  endtask

  task automatic test_streaming();
    int got = 0;
    int low = 0;
    for (int i = 0; i < 8; i++) mem_model[i] = 8'(i) ^ 8'h55;
    rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        n_cmp++; if (rsp_rdata !== (8'(got) ^ 8'h55)) begin n_bad++; $display("FAIL stream_data[%0d]: got %h want %h", got, rsp_rdata, 8'(got) ^ 8'h55); end
        n_cmp++; if (c != got + 3) begin n_bad++; $display("FAIL stream_timing[%0d]: got cycle %0d want %0d", got, c, got + 3); end
        got++;
      end
      if (c < 8) begin
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = AW'(c);
        if (cmd_ready !== 1'b1) low++;
      end else begin
        cmd_valid = 1'b0;
      end
    end
    n_cmp++; if (low != 0) begin n_bad++; $display("FAIL stream_ready_low: got %0d cycles want 0", low); end
    n_cmp++; if (got != 8) begin n_bad++; $display("FAIL stream_count: got %0d want 8", got); end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int got = 0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (idx < 6) begin cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = AW'(idx); end
      else cmd_valid = 1'b0;
      #1;
      if (cmd_valid && cmd_ready) idx++;
    end
    n_cmp++; if (idx != 4) begin n_bad++; $display("FAIL bp_accepted: got %0d want 4", idx); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_low: got %b want 0", cmd_ready); end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      rsp_ready = 1'b1;
      if (rsp_valid === 1'b1) begin
        n_cmp++; if (rsp_rdata !== (8'(got) ^ 8'h55)) begin n_bad++; $display("FAIL bp_data[%0d]: got %h want %h", got, rsp_rdata, 8'(got) ^ 8'h55); end
        got++;
      end
      if (idx < 6) begin cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = AW'(idx); end
      else cmd_valid = 1'b0;
      #1;
      if (cmd_valid && cmd_ready) idx++;
    end
    cmd_valid = 1'b0;
    n_cmp++; if (idx != 6) begin n_bad++; $display("FAIL bp_total_accepted: got %0d want 6", idx); end
    n_cmp++; if (got != 6) begin n_bad++; $display("FAIL bp_responses: got %0d want 6", got); end
  endtask

  task automatic test_raw();
    rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 9'h000; cmd_wdata = 8'hFF;
    @(negedge clk);
    cmd_we = 1'b0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL raw_ready: got %b want 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL raw_valid: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 8'hFF) begin n_bad++; $display("FAIL raw_data: got %h want ff", rsp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 9'h001;
    @(negedge clk);
    cmd_addr = 9'h002;
    @(negedge clk);
    cmd_valid = 1'b0;
    Reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 0", cmd_ready); end
    n_cmp++; if (mem_ren !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ren: got %b want 0", mem_ren); end
    Reset = 1'b0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL mid_release_ready: got %b want 1", cmd_ready); end
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) stale++;
    end
    n_cmp++; if (stale != 0) begin n_bad++; $display("FAIL mid_stale_rsp: got %0d valid cycles want 0", stale); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_streaming();
    test_backpressure();
    test_raw();
    test_reset_midflight();
    n_cmp++; if (collide != 0) begin n_bad++; $display("FAIL wen_ren_overlap: got %0d cycles want 0", collide); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
